// File: rtl/block_put_if.sv
// ---------------------------------------------------------------------------
// block_put_if
// Memory-side bus of the block write-back engine: one write port and one
// read port into the flat row-major result matrix buffer.
//
//   mem_we     write strobe            (master -> slave)
//   mem_waddr  write address           (master -> slave)
//   mem_wdata  write data              (master -> slave)
//   mem_re     read strobe             (master -> slave)
//   mem_raddr  read address            (master -> slave)
//   mem_rdata  read data, valid the cycle after mem_re (slave -> master)
// ---------------------------------------------------------------------------
interface block_put_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    output mem_rdata
  );
endinterface

// File: rtl/block_put.sv
// ---------------------------------------------------------------------------
// block_put
// Scatters a J x K tile from the compute array into a flat row-major matrix
// buffer, one element per cycle. Overwrite mode writes each in-bounds
// element; accumulate mode reads the element's location, then writes back
// the wrapped sum on the following cycle. Elements past the right or bottom
// matrix edge are skipped (one idle cycle each, no strobes).
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           request, sampled only in IDLE
//   start_row/col   tile origin inside the matrix
//   num_cols        matrix column count
//   matrix_len      total matrix elements (rows = matrix_len / num_cols)
//   accumulate      0 = overwrite, 1 = read-modify-write add
//   block_in        tile, element e = i*K+j at [e*DATA_W +: DATA_W]
//   mem             memory bus (block_put_if.master)
//   busy            operation in progress
//   block_put_done  one-cycle completion pulse
//   elems_written   writes performed by the last operation
//
// The state register names what the outputs show in the current cycle:
// RUN = overwrite write or skipped element, RD = read, ACC = accumulate
// write, DONE = completion pulse. Each edge therefore prepares the next
// element's strobes in advance, using the live inputs on the accepting edge
// and the latched operands afterwards.
// ---------------------------------------------------------------------------
module block_put #(
  parameter int DATA_W = 16,
  parameter int J      = 2,
  parameter int K      = 2,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_row,
  input  logic [ADDR_W-1:0]     start_col,
  input  logic [ADDR_W-1:0]     num_cols,
  input  logic [ADDR_W-1:0]     matrix_len,
  input  logic                  accumulate,
  input  logic [J*K*DATA_W-1:0] block_in,
  block_put_if.master           mem,
  output logic                  busy,
  output logic                  block_put_done,
  output logic [ADDR_W-1:0]     elems_written
);

  localparam int NE   = J * K;
  localparam int EW   = (NE > 1) ? $clog2(NE) : 1;
  localparam int LAST = NE - 1;
  // Wide enough for (row + i) * num_cols + num_cols without overflow.
  localparam int PW   = 2 * ADDR_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_RD, S_ACC, S_DONE} state_t;

  typedef struct packed {
    logic              inb;
    logic [ADDR_W-1:0] addr;
  } loc_t;

  // Row bound uses (row+1)*num_cols <= matrix_len, which is equivalent to
  // row < matrix_len / num_cols for num_cols > 0 and avoids a divider.
  function automatic loc_t locate(input logic [ADDR_W-1:0] row,
                                  input logic [ADDR_W-1:0] col,
                                  input logic [ADDR_W-1:0] ncols,
                                  input logic [ADDR_W-1:0] len,
                                  input logic [EW-1:0]     k);
    loc_t        res;
    int unsigned ki;
    logic [PW-1:0] rr, cc, nc, base;
    ki       = int'(k);
    rr       = PW'(row) + PW'(ki / K);
    cc       = PW'(col) + PW'(ki % K);
    nc       = PW'(ncols);
    base     = rr * nc;
    res.inb  = (cc < nc) && ((base + nc) <= PW'(len));
    res.addr = ADDR_W'(base + cc);
    return res;
  endfunction

  state_t                r_state;
  logic [ADDR_W-1:0]     r_row, r_col, r_ncols, r_len;
  logic                  r_acc;
  logic [NE*DATA_W-1:0]  r_block;
  logic [EW-1:0]         r_e;
  logic                  r_we, r_re, r_busy, r_done;
  logic [ADDR_W-1:0]     r_waddr, r_raddr, r_cnt;
  logic [DATA_W-1:0]     r_wdata;

  logic                  w_idle, w_last, w_degen, w_advance, w_src_acc;
  logic [ADDR_W-1:0]     w_src_row, w_src_col, w_src_ncols, w_src_len;
  logic [NE*DATA_W-1:0]  w_src_block;
  logic [EW-1:0]         w_next_e;
  logic [DATA_W-1:0]     w_elem;
  logic [ADDR_W-1:0]     w_cnt_base;
  loc_t                  w_loc;

  assign w_idle      = (r_state == S_IDLE);
  assign w_src_row   = w_idle ? start_row  : r_row;
  assign w_src_col   = w_idle ? start_col  : r_col;
  assign w_src_ncols = w_idle ? num_cols   : r_ncols;
  assign w_src_len   = w_idle ? matrix_len : r_len;
  assign w_src_acc   = w_idle ? accumulate : r_acc;
  assign w_src_block = w_idle ? block_in   : r_block;
  assign w_next_e    = w_idle ? '0 : r_e + EW'(1);
  assign w_cnt_base  = w_idle ? '0 : r_cnt;
  assign w_last      = (r_e == EW'(LAST));
  assign w_degen     = (num_cols == '0) || (matrix_len < num_cols);
  assign w_loc       = locate(w_src_row, w_src_col, w_src_ncols, w_src_len, w_next_e);

  // Another element is emitted on the accepting edge and after every
  // finished element except the last.
  assign w_advance = (w_idle && start && !w_degen) ||
                     ((r_state == S_RUN || r_state == S_ACC) && !w_last);

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_elem = '0;
    for (int e = 0; e < NE; e++) begin
      if (EW'(e) == w_next_e) w_elem = w_src_block[e*DATA_W +: DATA_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in this block deliberately
  // override the defaults and the case branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_ncols <= '0;
      r_len   <= '0;
      r_acc   <= 1'b0;
      r_block <= '0;
      r_e     <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= start_row;
            r_col   <= start_col;
            r_ncols <= num_cols;
            r_len   <= matrix_len;
            r_acc   <= accumulate;
            r_block <= block_in;
            r_cnt   <= '0;
            if (w_degen) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN, S_ACC: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_RD: begin
          // Write back to the address just read; the sum is formed on the
          // output because read data only arrives in the ACC cycle.
          r_state <= S_ACC;
          r_we    <= 1'b1;
          r_waddr <= r_raddr;
          r_cnt   <= r_cnt + ADDR_W'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_advance) begin
        r_busy <= 1'b1;
        r_e    <= w_next_e;
        if (!w_loc.inb) begin
          r_state <= S_RUN;
        end else if (w_src_acc) begin
          r_state <= S_RD;
          r_re    <= 1'b1;
          r_raddr <= w_loc.addr;
          r_wdata <= w_elem;          // held as the addend for ACC
        end else begin
          r_state <= S_RUN;
          r_we    <= 1'b1;
          r_waddr <= w_loc.addr;
          r_wdata <= w_elem;
          r_cnt   <= w_cnt_base + ADDR_W'(1);
        end
      end
    end
  end

  assign mem.mem_we      = r_we;
  assign mem.mem_re      = r_re;
  assign mem.mem_waddr   = r_waddr;
  assign mem.mem_raddr   = r_raddr;
  // Only the accumulate write has a path from mem_rdata; the sum wraps.
  assign mem.mem_wdata   = (r_state == S_ACC) ? r_wdata + mem.mem_rdata : r_wdata;
  assign busy            = r_busy;
  assign block_put_done  = r_done;
  assign elems_written   = r_cnt;

endmodule

// File: tb/tb_block_put.sv
// ---------------------------------------------------------------------------
// tb_block_put
// Directed bench for block_put: a behavioural memory, an expected-access
// queue filled from a reference model when each operation is launched, and
// per-cycle comparison of the memory strobes against that queue.
// ---------------------------------------------------------------------------
module tb_block_put;

  localparam int DATA_W = 16;
  localparam int J      = 2;
  localparam int K      = 2;
  localparam int ADDR_W = 10;

  typedef struct {
    bit          is_wr;
    int          cyc;
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  start_row = '0, start_col = '0, num_cols = '0, matrix_len = '0;
  logic        accumulate = 1'b0;
  logic [63:0] block_in = '0;
  logic        busy, block_put_done;
  logic [9:0]  elems_written;

  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem     [0:1023];
  logic [15:0] exp_mem [0:1023];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  block_put_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  block_put #(.DATA_W(DATA_W), .J(J), .K(K), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_row      (start_row),
    .start_col      (start_col),
    .num_cols       (num_cols),
    .matrix_len     (matrix_len),
    .accumulate     (accumulate),
    .block_in       (block_in),
    .mem            (bus),
    .busy           (busy),
    .block_put_done (block_put_done),
    .elems_written  (elems_written)
  );

  always #5 clk = ~clk;

  // Synchronous buffer: write on the edge, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (pre_we)          mem[pre_addr]      <= pre_data;
    else if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re)      bus.mem_rdata      <= mem[bus.mem_raddr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    exp_mem[a] = d;
  endtask

  // Reference model: walks the tile in row-major order and queues every
  // expected access with the cycle (1 = first cycle after acceptance) it
  // should appear in. Rows come from an integer divide.
  task automatic model(input logic [9:0] row, col, nc, len, input bit acc,
                       input logic [63:0] blk, output int done_cyc, output int n_wr);
    int rows, cyc, a;
    logic [15:0] el, nv;
    exp_t it;
    n_wr = 0;
    rows = (nc == 0) ? 0 : int'(len) / int'(nc);
    cyc  = 1;
    if (rows > 0) begin
      for (int i = 0; i < J; i++) begin
        for (int j = 0; j < K; j++) begin
          el = blk[(i*K+j)*16 +: 16];
          if ((int'(row) + i < rows) && (int'(col) + j < int'(nc))) begin
            a = ((int'(row) + i) * int'(nc) + int'(col) + j) % 1024;
            if (acc) begin
              it = '{is_wr: 1'b0, cyc: cyc, addr: 10'(a), data: '0};
              sb.push_back(it);
              nv = exp_mem[a] + el;
              it = '{is_wr: 1'b1, cyc: cyc + 1, addr: 10'(a), data: nv};
              sb.push_back(it);
              cyc += 2;
            end else begin
              nv = el;
              it = '{is_wr: 1'b1, cyc: cyc, addr: 10'(a), data: nv};
              sb.push_back(it);
              cyc += 1;
            end
            exp_mem[a] = nv;
            n_wr++;
          end else begin
            cyc += 1;
          end
        end
      end
    end
    done_cyc = cyc;
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".we"},    32'(bus.mem_we), 0);
    check({name, ".re"},    32'(bus.mem_re), 0);
    check({name, ".waddr"}, 32'(bus.mem_waddr), 0);
    check({name, ".raddr"}, 32'(bus.mem_raddr), 0);
    check({name, ".wdata"}, 32'(bus.mem_wdata), 0);
    check({name, ".busy"},  32'(busy), 0);
    check({name, ".done"},  32'(block_put_done), 0);
    check({name, ".elems"}, 32'(elems_written), 0);
  endtask

  // Launches one operation and follows it cycle by cycle. pulse_cyc > 0
  // raises a stray start in that cycle; pulse_done raises one during the
  // done pulse; abort_after > 0 asserts reset in the cycle after that many
  // writes have been observed.
  task automatic run_op(input string name, input logic [9:0] row, col, nc, len,
                        input bit acc, input logic [63:0] blk, input int pulse_cyc,
                        input bit pulse_done, input int abort_after);
    int done_cyc, n_wr, writes_seen;
    bit finished, abort_pend;
    exp_t it;
    model(row, col, nc, len, acc, blk, done_cyc, n_wr);
    @(negedge clk);
    start_row = row; start_col = col; num_cols = nc; matrix_len = len;
    accumulate = acc; block_in = blk; start = 1'b1;
    @(posedge clk);
    #1;
    // Operands are latched; scramble them to prove it.
    start = 1'b0; start_row = 10'h3FF; start_col = 10'h3FF; num_cols = 10'd1;
    matrix_len = 10'd0; accumulate = ~acc; block_in = ~blk;
    finished = 1'b0; abort_pend = 1'b0; writes_seen = 0;
    for (int c = 1; c <= 64 && !finished; c++) begin
      @(negedge clk);
      check($sformatf("%s.we_re_excl.c%0d", name, c), 32'(bus.mem_we & bus.mem_re), 0);
      if (bus.mem_we || bus.mem_re) begin
        if (sb.size() == 0) begin
          check($sformatf("%s.unexpected_strobe.c%0d", name, c), 32'(sb.size()), 1);
        end else begin
          it = sb.pop_front();
          check($sformatf("%s.kind.c%0d", name, c), 32'(bus.mem_we), 32'(it.is_wr));
          check($sformatf("%s.cycle", name), 32'(c), 32'(it.cyc));
          if (it.is_wr) begin
            check($sformatf("%s.waddr.c%0d", name, c), 32'(bus.mem_waddr), 32'(it.addr));
            check($sformatf("%s.wdata.c%0d", name, c), 32'(bus.mem_wdata), 32'(it.data));
          end else begin
            check($sformatf("%s.raddr.c%0d", name, c), 32'(bus.mem_raddr), 32'(it.addr));
          end
        end
        if (bus.mem_we) writes_seen++;
      end
      if (abort_pend) begin
        #1 rst = 1'b1;
        #1 check_all_zero({name, ".async_rst"});
        sb.delete();
        repeat (3) begin
          @(negedge clk);
          check({name, ".rst_no_we"}, 32'(bus.mem_we), 0);
          check({name, ".rst_no_re"}, 32'(bus.mem_re), 0);
        end
        rst = 1'b0;
        finished = 1'b1;
      end else if (block_put_done) begin
        check({name, ".done_cycle"}, 32'(c), 32'(done_cyc));
        check({name, ".elems"}, 32'(elems_written), 32'(n_wr));
        check({name, ".busy_at_done"}, 32'(busy), 0);
        check({name, ".sb_drained"}, 32'(sb.size()), 0);
        if (pulse_done) begin
          start_row = 10'd0; start_col = 10'd0; num_cols = 10'd4; matrix_len = 10'd16;
          accumulate = 1'b0; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check({name, ".post_busy"}, 32'(busy), 0);
        check({name, ".post_we"},   32'(bus.mem_we | bus.mem_re), 0);
        check({name, ".post_done"}, 32'(block_put_done), 0);
        check({name, ".elems_hold"}, 32'(elems_written), 32'(n_wr));
        finished = 1'b1;
      end else begin
        check($sformatf("%s.busy.c%0d", name, c), 32'(busy), 1);
        if (abort_after > 0 && writes_seen == abort_after) abort_pend = 1'b1;
        if (c == pulse_cyc) begin
          start_row = 10'd0; start_col = 10'd0; num_cols = 10'd4; matrix_len = 10'd16;
          accumulate = 1'b1; start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    check({name, ".completed"}, 32'(finished), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Overwrite with interior origin; stray start while busy and at done.
    run_op("s1_overwrite", 10'd1, 10'd1, 10'd4, 10'd16, 1'b0,
           {16'd4, 16'd3, 16'd2, 16'd1}, 2, 1'b1, 0);

    // Bottom-right corner: only element 0 lands inside.
    run_op("s2_corner", 10'd3, 10'd3, 10'd4, 10'd16, 1'b0,
           {16'h00DD, 16'h00CC, 16'h00BB, 16'h00AA}, 0, 1'b0, 0);

    // Accumulate, including a wrapping sum.
    preload(10'd0, 16'd10);
    preload(10'd1, 16'hFFFF);
    preload(10'd4, 16'd0);
    preload(10'd5, 16'd5);
    run_op("s3_accum", 10'd0, 10'd0, 10'd4, 10'd16, 1'b1,
           {16'd1, 16'd3, 16'd2, 16'd7}, 0, 1'b0, 0);
    @(negedge clk);
    check("s3_mem0", 32'(mem[0]), 17);
    check("s3_mem1", 32'(mem[1]), 32'h0001);
    check("s3_mem4", 32'(mem[4]), 3);
    check("s3_mem5", 32'(mem[5]), 6);

    // Degenerate matrices: no columns, and fewer elements than one row.
    run_op("s4_ncols0", 10'd2, 10'd1, 10'd0, 10'd16, 1'b0,
           {16'd9, 16'd9, 16'd9, 16'd9}, 0, 1'b0, 0);
    run_op("s4_short", 10'd0, 10'd0, 10'd8, 10'd4, 1'b1,
           {16'd9, 16'd9, 16'd9, 16'd9}, 0, 1'b0, 0);

    // Ragged length: 7 elements / 3 cols = 2 rows; accumulate with clipping.
    preload(10'd5, 16'h0100);
    run_op("s6_ragged", 10'd1, 10'd2, 10'd3, 10'd7, 1'b1,
           {16'h0044, 16'h0033, 16'h0022, 16'h0020}, 0, 1'b0, 0);
    @(negedge clk);
    check("s6_mem5", 32'(mem[5]), 32'h0120);

    // Reset in the middle of an overwrite, then a clean rerun.
    preload(10'd6,  16'h5555);
    preload(10'd9,  16'hDEAD);
    preload(10'd10, 16'hBEEF);
    run_op("s5_abort", 10'd1, 10'd1, 10'd4, 10'd16, 1'b0,
           {16'd4, 16'd3, 16'd2, 16'd1}, 0, 1'b0, 2);
    check("s5_mem6_written",  32'(mem[6]),  32'h0002);
    check("s5_mem9_untouched",  32'(mem[9]),  32'hDEAD);
    check("s5_mem10_untouched", 32'(mem[10]), 32'hBEEF);
    run_op("s5_rerun", 10'd1, 10'd1, 10'd4, 10'd16, 1'b0,
           {16'd4, 16'd3, 16'd2, 16'd1}, 0, 1'b0, 0);
    @(negedge clk);
    check("s5_mem9",  32'(mem[9]),  32'h0003);
    check("s5_mem10", 32'(mem[10]), 32'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_put.md
Name: block_put

Overview:
- Write-back counterpart of the block extractor. Takes a J x K tile from the systolic/compute array and scatters it into the flat row-major matrix buffer through a single-port-write, single-port-read memory interface.
- Each start writes one element per cycle. In accumulate mode it does a read-modify-write for each element.
- Tile elements that fall outside the matrix (right or bottom edge) are clipped: they are never written.
- Sits between the compute array output and the result matrix buffer. Driven by the top-level tiling controller.

Parameters:
DATA_W, 16, element width in bits (defaults to `DATA_W)
J, 2, tile rows (defaults to `J)
K, 2, tile columns (defaults to `K)
ADDR_W, 10, matrix buffer address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
start_row  in  10  top row of tile in matrix
start_col  in  10  left column of tile in matrix
num_cols  in  10  matrix column count
matrix_len  in  10  total matrix elements (rows = matrix_len / num_cols, integer divide)
accumulate  in  1  0 = overwrite, 1 = mem += tile element
block_in  in  J*K*DATA_W  tile; element e = i*K+j at bits [e*DATA_W +: DATA_W]
mem_we  out  1  write strobe
mem_waddr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_re  out  1  read strobe
mem_raddr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re
busy  out  1  high from the cycle after start is accepted until done
block_put_done  out  1  one-cycle completion pulse
elems_written  out  ADDR_W  count of writes performed by the last operation

Behaviour:
- Reset (async, any state): FSM to IDLE. mem_we, mem_re, busy and block_put_done go to 0. mem_waddr, mem_raddr, mem_wdata and elems_written go to 0. Any in-flight operation is abandoned with no further memory access.
- Start acceptance: start=1 in IDLE at edge T0 latches all operands, block_in and accumulate, clears elems_written and enters RUN. Inputs may change afterwards.
- Start ignored: start is ignored when not in IDLE, including the cycle block_put_done is high.
- Degenerate matrix: num_cols=0 or matrix_len<num_cols means zero rows. The FSM goes IDLE -> DONE directly with no memory access. block_put_done is high in cycle T0+1 and elems_written=0.
- Element order: elements are processed in order e=0..J*K-1, row-major, via an element counter.
- Bounds test: element (i,j) is in bounds iff start_row+i < rows AND start_col+j < num_cols. Compute in 11+ bits so no overflow.
- Address: addr = (start_row+i)*num_cols + (start_col+j), truncated to ADDR_W.
- States: IDLE, RUN, RD, ACC, DONE.
  - RUN, out of bounds: 1 cycle, no strobes, advance e.
  - RUN, in bounds, accumulate=0: 1 cycle with mem_we=1, mem_waddr=addr, mem_wdata=element; elems_written+1; advance e.
  - RUN, in bounds, accumulate=1: that cycle acts as RD. mem_re=1, mem_raddr=addr, no write.
  - ACC (next cycle): mem_we=1, mem_waddr=addr, mem_wdata = mem_rdata + element, modulo 2^DATA_W with carry discarded. elems_written+1; advance e.
  - After the last element, go to DONE.
- DONE: block_put_done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: overwrite mode is always J*K element cycles, so done is at T0+J*K+1. Accumulate mode adds one cycle per in-bounds element.
- Strobe rules: mem_we and mem_re are never high in the same cycle. Addresses and data are registered outputs.
- Hold behaviour: elems_written holds until the next accepted start or reset.

Test Plan:
1. Overwrite, num_cols=4, matrix_len=16, start (1,1), block {1,2,3,4} -> writes addr5=1, addr6=2, addr9=3, addr10=4 in cycles T0+1..T0+4. Done pulse at T0+5; elems_written=4.
2. Corner clip, start (3,3), num_cols=4, len=16 -> single write addr15=elem0. Three idle element cycles with no strobes; done at T0+5; elems_written=1.
3. Accumulate, start (0,0), num_cols=4, len=16, mem[0]=10, mem[1]=0xFFFF, mem[4]=0, mem[5]=5, block {7,2,3,1} -> mem[0]=17, mem[1]=0x0001, mem[4]=3, mem[5]=6. Each write comes 1 cycle after its read; done at T0+9.
4. num_cols=0 with start -> no strobes; done at T0+1; elems_written=0. A start pulse while busy in scenario 1 -> ignored, and the write sequence is unchanged.
5. Async reset asserted mid-run, after the 2nd write of scenario 1 -> all outputs 0 immediately without a clock edge. No further writes; after release, a new start runs normally.
